// File: rtl/hilo_multu_unit.sv
// rtl/hilo_multu_unit.sv - iterative shift-add MULTU unit owning the HI/LO register pair
module hilo_multu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             WE_R64,
    input  logic [2:0]       ALU_Ctrl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [2:0] ALU_MULTU = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        COMMIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               start;

    // The stalled instruction keeps WE_R64 high through RUN; the IDLE term stops retriggering.
    assign start = WE_R64 && (ALU_Ctrl == ALU_MULTU) && (state == IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST_CNT) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            HI     <= '0;
            LO     <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, SrcA};
                        mplier <= SrcB;
                        acc    <= '0;
                        cnt    <= '0;
                        Busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                COMMIT: begin
                    // Done rises with the new HI/LO and Busy drops in the same edge.
                    HI   <= acc[2*WIDTH-1:WIDTH];
                    LO   <= acc[WIDTH-1:0];
                    Done <= 1'b1;
                    Busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_multu_unit.sv
// tb/tb_hilo_multu_unit.sv - randomized self-checking bench for hilo_multu_unit
module tb_hilo_multu_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         WE_R64;
    logic [2:0]   ALU_Ctrl;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
    logic         Busy;
    logic         Done;

    int checks;
    int errors;
    logic [2*W-1:0] hilo_model;

    hilo_multu_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .WE_R64   (WE_R64),
        .ALU_Ctrl (ALU_Ctrl),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .HI       (HI),
        .LO       (LO),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called on a negedge; returns on a negedge. chain=1 leaves WE_R64 high at the Done cycle.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit mutate, input bit chain, input string name);
        logic [2*W-1:0] exp_prod;
        int busy_n;
        bit seen;
        bit hold_ok;
        exp_prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        SrcA = a;
        SrcB = b;
        WE_R64 = 1'b1;
        ALU_Ctrl = 3'b011;
        busy_n = 0;
        seen = 1'b0;
        hold_ok = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (Done) begin
                seen = 1'b1;
            end else begin
                if (Busy) busy_n++;
                if ({HI, LO} !== hilo_model) hold_ok = 1'b0;
                if (mutate && busy_n == 3) begin
                    SrcA = 32'd5;
                    SrcB = $urandom;
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout: no Done within 100 cycles", name);
        end
        checks++;
        if ({HI, LO} !== exp_prod) begin
            errors++;
            $display("FAIL %s product: got HI=%h LO=%h expected HI=%h LO=%h",
                     name, HI, LO, exp_prod[2*W-1:W], exp_prod[W-1:0]);
        end
        checks++;
        if (busy_n != W + 1) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, W + 1);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b expected 0", name, Busy);
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL %s hilo_hold: HI/LO changed before commit, expected %h", name, hilo_model);
        end
        hilo_model = exp_prod;
        if (!chain) begin
            WE_R64 = 1'b0;
            @(negedge clk);
            checks++;
            if (Done !== 1'b0 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL %s after_done: got Done=%b Busy=%b expected 0 0", name, Done, Busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        WE_R64 = 1'b0;
        ALU_Ctrl = 3'b000;
        SrcA = '0;
        SrcB = '0;
        hilo_model = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (HI !== '0 || LO !== '0 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got HI=%h LO=%h Busy=%b Done=%b expected all 0", HI, LO, Busy, Done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_mul(32'd7, 32'd6, 1'b0, 1'b0, "basic_7x6");
    endtask

    task automatic test_max();
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "max");
        checks++;
        if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
            errors++;
            $display("FAIL max_const: got HI=%h LO=%h expected HI=fffffffe LO=00000001", HI, LO);
        end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (HI !== '0 || LO !== '0 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got HI=%h LO=%h Busy=%b Done=%b expected all 0", HI, LO, Busy, Done);
        end
        hilo_model = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_operand_hold();
        run_mul($urandom, $urandom, 1'b1, 1'b0, "operand_hold");
    endtask

    task automatic test_ignore_ctrl();
        bit bad;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) continue;
            WE_R64 = 1'b1;
            ALU_Ctrl = 3'(c);
            SrcA = $urandom;
            SrcB = $urandom;
            repeat (4) begin
                @(negedge clk);
                if (Busy !== 1'b0 || Done !== 1'b0 || {HI, LO} !== hilo_model) bad = 1'b1;
            end
        end
        WE_R64 = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL ignore_ctrl: got Busy=%b Done=%b HI=%h LO=%h expected idle, HI:LO=%h",
                     Busy, Done, HI, LO, hilo_model);
        end
    endtask

    task automatic test_abort();
        int done_n;
        SrcA = 32'd3;
        SrcB = 32'd4;
        WE_R64 = 1'b1;
        ALU_Ctrl = 3'b011;
        repeat (10) @(negedge clk);
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: got %b expected 1 before reset", Busy);
        end
        #2 rst_n = 1'b0;
        #1;
        WE_R64 = 1'b0;
        hilo_model = '0;
        checks++;
        if (HI !== '0 || LO !== '0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: got HI=%h LO=%h Busy=%b expected 0 0 0", HI, LO, Busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) done_n++;
        end
        checks++;
        if (done_n != 0 || HI !== '0 || LO !== '0) begin
            errors++;
            $display("FAIL abort_no_done: got Done pulses=%0d HI=%h LO=%h expected 0 0 0", done_n, HI, LO);
        end
        run_mul(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back();
        run_mul(32'd2, 32'd3, 1'b0, 1'b1, "b2b_first");
        run_mul(32'd5, 32'd5, 1'b0, 1'b0, "b2b_second");
        checks++;
        if (LO !== 32'd25 || HI !== 32'd0) begin
            errors++;
            $display("FAIL b2b_const: got HI=%h LO=%h expected 0 25", HI, LO);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_mul($urandom, $urandom, 1'b0, (i % 2) == 0, "random");
        end
        run_mul(32'd0, $urandom, 1'b0, 1'b0, "zero_a");
        run_mul($urandom, 32'd1, 1'b0, 1'b0, "one_b");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_max();
        test_async_reset();
        test_operand_hold();
        test_ignore_ctrl();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
